plant_emulator: RTL and testbench

PLANT_EMULATOR -- requirements
Module: plant_emulator

---
 rtl/plant_pkg.sv | 29 ++
 rtl/plant_emulator_lfsr16.sv | 25 ++
 rtl/plant_emulator.sv | 187 ++++++++++++++++++
 tb/tb_plant_emulator.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/plant_pkg.sv
// Shared constants, LFSR helper and FSM state type for the plant emulator.
package plant_pkg;

  localparam int unsigned W1_DEFAULT = 12;
  localparam int unsigned DW_DEFAULT = 14;
  localparam int unsigned L_DEFAULT  = 16;

  localparam int unsigned LFSR_W = 16;
  localparam int unsigned HW     = 12;
  localparam int unsigned CW     = 16;
  localparam int unsigned PW     = HW + CW;
  localparam int unsigned ACC_W  = 34;
  localparam int unsigned FRAC_W = 10;

  localparam logic [LFSR_W-1:0] LFSR_SEED  = 16'hACE1;
  localparam logic [LFSR_W-1:0] NOISE_SEED = 16'h1D2B;
  // Right-shifting Fibonacci form of taps 16,14,13,11 (bits 0,2,3,5).
  localparam logic [LFSR_W-1:0] LFSR_TAP_MASK = 16'h002D;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1
  } state_e;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] q);
    return {^(q & LFSR_TAP_MASK), q[LFSR_W-1:1]};
  endfunction

endpackage

// File: rtl/plant_emulator_lfsr16.sv
// 16-bit Fibonacci LFSR that advances one step per enabled clock.
module lfsr16
  import plant_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  output logic [15:0] q
);

  logic [15:0] q_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q <= SEED;
    end else if (en) begin
      q_q <= lfsr_step(q_q);
    end
  end

  assign q = q_q;

endmodule

// File: rtl/plant_emulator.sv
// FIR plant model excited by an LFSR; produces x/d sample pairs for an adaptive filter.
// Optional build macro PLANT_NOISE_EN adds a small LFSR noise term to d before saturation.
module plant_emulator #(
  parameter int unsigned W1 = plant_pkg::W1_DEFAULT,
  parameter int unsigned DW = plant_pkg::DW_DEFAULT,
  parameter int unsigned L  = plant_pkg::L_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stop,
  input  logic          sample_en,
  input  logic          coef_wr,
  input  logic [3:0]    coef_addr,
  input  logic [15:0]   coef_data,
  output logic [W1-1:0] x_out,
  output logic [DW-1:0] d_out,
  output logic          valid,
  output logic [1:0]    state_out,
  output logic          sat_flag,
  output logic          wr_err
);

  import plant_pkg::*;

  localparam logic signed [ACC_W-1:0] D_MAX = ACC_W'((1 << (DW - 1)) - 1);
  localparam logic signed [ACC_W-1:0] D_MIN = ~D_MAX;

  state_e state_q, state_d;
  logic   accept_c;
  logic   coef_we_c;
  logic   wr_reject_c;

  logic [15:0]             lfsr_q;
  logic signed [HW-1:0]    h_q [L];
  logic signed [HW-1:0]    h_d [L];
  logic signed [CW-1:0]    c_q [L];
  logic signed [ACC_W-1:0] acc_c;
  logic signed [ACC_W-1:0] noise_c;
  logic signed [ACC_W-1:0] noisy_c;
  logic [DW-1:0]           d_sat_c;
  logic                    sat_c;

  logic [W1-1:0] x_q;
  logic [DW-1:0] d_q;
  logic          valid_q;
  logic          sat_q;
  logic          wr_err_q;

  // Run/idle control; stop has priority over start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    accept_c    = 1'b0;
    coef_we_c   = 1'b0;
    wr_reject_c = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        coef_we_c = coef_wr;
        if (start && !stop) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        accept_c    = sample_en;
        wr_reject_c = coef_wr;
        if (stop) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  lfsr16 #(.SEED(LFSR_SEED)) u_exc (
    .clk   (clk),
    .reset (reset),
    .en    (accept_c),
    .q     (lfsr_q)
  );

  logic lfsr_unused;
  assign lfsr_unused = ^lfsr_q[15:HW];

`ifdef PLANT_NOISE_EN
  logic [15:0] noise_q;
  logic        noise_unused;

  lfsr16 #(.SEED(NOISE_SEED)) u_noise (
    .clk   (clk),
    .reset (reset),
    .en    (accept_c),
    .q     (noise_q)
  );

  assign noise_unused = ^noise_q[15:4];
  assign noise_c      = ACC_W'($signed({1'b0, noise_q[3:0]})) - ACC_W'(8);
`else
  assign noise_c = '0;
`endif

  // Tap line as it will look after this sample: new LFSR value enters at h[0].
  always_comb begin
    h_d[0] = lfsr_q[HW-1:0];
    for (int i = 1; i < L; i++) begin
      h_d[i] = h_q[i-1];
    end
  end

  // Convolution on the updated taps, Q5.10 rescale, optional noise, then clamp.
  always_comb begin
    acc_c = '0;
    for (int i = 0; i < L; i++) begin
      acc_c = acc_c + ACC_W'(PW'(h_d[i]) * PW'(c_q[i]));
    end
    noisy_c = (acc_c >>> FRAC_W) + noise_c;
    sat_c   = 1'b0;
    d_sat_c = noisy_c[DW-1:0];
    if (noisy_c > D_MAX) begin
      d_sat_c = D_MAX[DW-1:0];
      sat_c   = 1'b1;
    end else if (noisy_c < D_MIN) begin
      d_sat_c = D_MIN[DW-1:0];
      sat_c   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < L; i++) begin
        h_q[i] <= '0;
      end
    end else if (accept_c) begin
      for (int i = 0; i < L; i++) begin
        h_q[i] <= h_d[i];
      end
    end
  end

  // Coefficients are only writable while idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < L; i++) begin
        c_q[i] <= '0;
      end
    end else if (coef_we_c && (32'(coef_addr) < L)) begin
      c_q[coef_addr] <= coef_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_q      <= '0;
      d_q      <= '0;
      valid_q  <= 1'b0;
      sat_q    <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      valid_q <= accept_c;
      if (accept_c) begin
        x_q <= W1'(h_d[0]);
        d_q <= d_sat_c;
        if (sat_c) begin
          sat_q <= 1'b1;
        end
      end
      if (wr_reject_c) begin
        wr_err_q <= 1'b1;
      end
    end
  end

  assign x_out     = x_q;
  assign d_out     = d_q;
  assign valid     = valid_q;
  assign state_out = state_q;
  assign sat_flag  = sat_q;
  assign wr_err    = wr_err_q;

endmodule

// File: tb/tb_plant_emulator.sv
// Scoreboard bench for plant_emulator: stimulus pushes expected x/d pairs, a monitor pops them on valid.
module tb_plant_emulator;

  logic        clk;
  logic        reset;
  logic        start;
  logic        stop;
  logic        sample_en;
  logic        coef_wr;
  logic [3:0]  coef_addr;
  logic [15:0] coef_data;
  logic [11:0] x_out;
  logic [13:0] d_out;
  logic        valid;
  logic [1:0]  state_out;
  logic        sat_flag;
  logic        wr_err;

  plant_emulator dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .sample_en (sample_en),
    .coef_wr   (coef_wr),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .x_out     (x_out),
    .d_out     (d_out),
    .valid     (valid),
    .state_out (state_out),
    .sat_flag  (sat_flag),
    .wr_err    (wr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] x;
    logic [13:0] d;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  logic [15:0]        m_lfsr;
  logic [15:0]        m_noise;
  logic signed [11:0] m_h [16];
  logic signed [15:0] m_c [16];
  bit                 m_run;

  function automatic logic [15:0] ref_lfsr(input logic [15:0] q);
    logic fb;
    fb = q[0] ^ q[2] ^ q[3] ^ q[5];
    return {fb, q[15:1]};
  endfunction

  task automatic model_reset();
    m_lfsr  = 16'hACE1;
    m_noise = 16'h1D2B;
    m_run   = 1'b0;
    for (int i = 0; i < 16; i++) begin
      m_h[i] = '0;
      m_c[i] = '0;
    end
  endtask

  task automatic model_sample(output logic [11:0] xe, output logic [13:0] de);
    longint acc;
    longint q;
    for (int i = 15; i > 0; i--) m_h[i] = m_h[i-1];
    m_h[0] = m_lfsr[11:0];
    acc = 0;
    for (int i = 0; i < 16; i++) acc += longint'(m_h[i]) * longint'(m_c[i]);
    q = acc >>> 10;
`ifdef PLANT_NOISE_EN
    q = q + longint'(m_noise[3:0]) - 8;
    m_noise = ref_lfsr(m_noise);
`endif
    if (q > 8191) q = 8191;
    else if (q < -8192) q = -8192;
    xe = m_h[0];
    de = q[13:0];
    m_lfsr = ref_lfsr(m_lfsr);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset     = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
    sample_en = 1'b0;
    coef_wr   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    sb.delete();
    model_reset();
    step();
    step();
    check("rst_state", 32'(state_out), 32'd0);
    check("rst_x", 32'(x_out), 32'd0);
    check("rst_d", 32'(d_out), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_sat", 32'(sat_flag), 32'd0);
    check("rst_wr_err", 32'(wr_err), 32'd0);
    reset = 1'b1;
    step();
  endtask

  task automatic write_coef(input logic [3:0] addr, input logic [15:0] data);
    coef_wr   = 1'b1;
    coef_addr = addr;
    coef_data = data;
    step();
    coef_wr = 1'b0;
    if (!m_run) m_c[addr] = data;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    m_run = 1'b1;
    check("state_run", 32'(state_out), 32'd1);
  endtask

  task automatic do_start_stop();
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    m_run = 1'b0;
    check("state_start_stop", 32'(state_out), 32'd0);
  endtask

  task automatic sample_model();
    logic [11:0] xe;
    logic [13:0] de;
    sample_en = 1'b1;
    if (m_run) begin
      model_sample(xe, de);
      sb.push_back('{x: xe, d: de});
    end
    step();
    sample_en = 1'b0;
    check("valid_latency", 32'(valid), m_run ? 32'd1 : 32'd0);
  endtask

  // Directed sample with hand-derived expectation; the model still advances to stay in step.
  task automatic sample_hand(input logic [11:0] xh, input logic [13:0] dh);
    logic [11:0] xe;
    logic [13:0] de;
    sample_en = 1'b1;
    model_sample(xe, de);
`ifdef PLANT_NOISE_EN
    sb.push_back('{x: xh, d: de});
`else
    sb.push_back('{x: xh, d: dh});
`endif
    step();
    sample_en = 1'b0;
    check("valid_latency", 32'(valid), 32'd1);
  endtask

  // Monitor: every valid pops one expected pair.
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b1 && valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid x=%0h d=%0h at %0t", x_out, d_out, $time);
      end else begin
        e = sb.pop_front();
        checks += 2;
        if (x_out !== e.x) begin
          errors++;
          $display("FAIL x_out got=%0h exp=%0h at %0t", x_out, e.x, $time);
        end
        if (d_out !== e.d) begin
          errors++;
          $display("FAIL d_out got=%0h exp=%0h at %0t", d_out, e.d, $time);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    apply_reset();

    // Sample in IDLE is ignored; start+stop in IDLE stays IDLE.
    sample_model();
    do_start_stop();
    do_start();
    sample_hand(12'hCE1, 14'h0000);
    sample_hand(12'h670, 14'h0000);
    sample_hand(12'hB38, 14'h0000);
    sample_hand(12'h59C, 14'h0000);
    step();

    // Identity tap: d follows x.
    apply_reset();
    write_coef(4'd0, 16'd1024);
    do_start();
    for (int i = 0; i < 20; i++) sample_model();
    step();
    check("sat_clear_identity", 32'(sat_flag), 32'd0);

    // Delay by three taps.
    apply_reset();
    write_coef(4'd3, 16'd1024);
    do_start();
    sample_hand(12'hCE1, 14'h0000);
    sample_hand(12'h670, 14'h0000);
    sample_hand(12'hB38, 14'h0000);
    sample_hand(12'h59C, 14'h3CE1);
    sample_hand(12'hACE, 14'h0670);
    for (int i = 0; i < 5; i++) sample_model();
    step();

    // Full-scale coefficients force saturation.
    apply_reset();
    for (int i = 0; i < 16; i++) write_coef(4'(i), 16'h7FFF);
    do_start();
    for (int i = 0; i < 50; i++) sample_model();
    step();
    check("sat_flag_set", 32'(sat_flag), 32'd1);

    // Write during RUN rejected; stop/start keeps LFSR and taps.
    apply_reset();
    write_coef(4'd0, 16'd1024);
    do_start();
    sample_model();
    write_coef(4'd0, 16'd0);
    check("wr_err_set", 32'(wr_err), 32'd1);
    for (int i = 0; i < 3; i++) sample_model();
    do_start_stop();
    sample_model();
    sample_model();
    do_start();
    for (int i = 0; i < 4; i++) sample_model();
    step();
    check("wr_err_sticky", 32'(wr_err), 32'd1);

    // Reset in the middle of a run aborts immediately.
    apply_reset();
    do_start();
    for (int i = 0; i < 5; i++) sample_model();
    write_coef(4'd1, 16'd5);
    step();
    sample_en = 1'b1;
    reset     = 1'b0;
    #1;
    check("abort_valid", 32'(valid), 32'd0);
    check("abort_state", 32'(state_out), 32'd0);
    check("abort_x", 32'(x_out), 32'd0);
    check("abort_wr_err", 32'(wr_err), 32'd0);
    apply_reset();
    sample_en = 1'b1;
    step();
    step();
    sample_en = 1'b0;
    check("idle_after_reset", 32'(valid), 32'd0);
    do_start();
    sample_hand(12'hCE1, 14'h0000);
    sample_hand(12'h670, 14'h0000);
    step();
    step();

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
